// File: rtl/cam_sequencer_if.sv
// Transaction-level I2C master bus between the camera sequencer and the I2C master.
`timescale 1ns/1ps
interface cam_sequencer_if;
  logic        m_start;
  logic [6:0]  m_addr;
  logic        m_rw;
  logic [4:0]  m_len;
  logic [15:0] m_wdata;
  logic        m_done;
  logic        m_nack;
  logic [7:0]  m_rdata;
  logic        m_rvalid;

  modport master (
    output m_start, m_addr, m_rw, m_len, m_wdata,
    input  m_done, m_nack, m_rdata, m_rvalid
  );

  modport slave (
    input  m_start, m_addr, m_rw, m_len, m_wdata,
    output m_done, m_nack, m_rdata, m_rvalid
  );
endinterface

// File: rtl/cam_sequencer.sv
// IR camera sequencer: one-shot register init, then periodic pointer-write/16-byte-read
// polling with blob-1 decode, NACK backoff and a sticky fault after repeated failures.
`timescale 1ns/1ps
module cam_sequencer #(
  parameter logic [6:0]  DEV_ADDR    = 7'h58,
  parameter int unsigned GAP_CYCLES  = 16,
  parameter int unsigned POLL_CYCLES = 64,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  cam_sequencer_if.master bus,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [3:0] size,
  output logic       blob_seen,
  output logic       pos_valid,
  output logic       init_done,
  output logic       busy,
  output logic       fault,
  output logic       err_pulse
);

  localparam int unsigned MAXC = (GAP_CYCLES > POLL_CYCLES) ? GAP_CYCLES : POLL_CYCLES;
  localparam int unsigned TW   = $clog2(MAXC + 1);
  localparam int unsigned RW   = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] POLL_LOAD = TW'(POLL_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [RW-1:0] RETRY_SAT = RW'(MAX_RETRY + 1);

  typedef enum logic [3:0] {
    IDLE, INIT_ISSUE, INIT_WAIT, INIT_GAP, BACKOFF,
    PTR_ISSUE, PTR_WAIT, PTR_GAP, RD_ISSUE, RD_WAIT,
    PUBLISH, POLL_WAIT, FAULT
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [RW-1:0]   retry_q, retry_d, retry_inc;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [4:0]      cnt_q, cnt_d, cnt_nxt;
  logic [7:0]      b1_q, b1_d, b2_q, b2_d, b3_q, b3_d;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic [3:0]      size_q, size_d;
  logic            init_done_q, init_done_d;

  function automatic logic [15:0] init_word(input logic [2:0] i);
    case (i)
      3'd0:    init_word = 16'h3001;
      3'd1:    init_word = 16'h3008;
      3'd2:    init_word = 16'h0690;
      3'd3:    init_word = 16'h08C0;
      3'd4:    init_word = 16'h1A40;
      default: init_word = 16'h3333;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      retry_q     <= '0;
      tmr_q       <= '0;
      cnt_q       <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      b3_q        <= '0;
      x_q         <= '1;
      y_q         <= '1;
      size_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      tmr_q       <= tmr_d;
      cnt_q       <= cnt_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      b3_q        <= b3_d;
      x_q         <= x_d;
      y_q         <= y_d;
      size_q      <= size_d;
      init_done_q <= init_done_d;
    end
  end

  assign retry_inc = (retry_q == RETRY_SAT) ? retry_q : retry_q + RW'(1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    tmr_d       = tmr_q;
    cnt_d       = cnt_q;
    cnt_nxt     = cnt_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    b3_d        = b3_q;
    x_d         = x_q;
    y_d         = y_q;
    size_d      = size_q;
    init_done_d = init_done_q;
    err_pulse   = 1'b0;

    case (state_q)
      IDLE, FAULT: begin
        if (start) begin
          state_d     = INIT_ISSUE;
          idx_d       = '0;
          retry_d     = '0;
          init_done_d = 1'b0;
        end
      end
      INIT_ISSUE: state_d = INIT_WAIT;
      INIT_WAIT: begin
        if (bus.m_done) begin
          if (bus.m_nack) begin
            err_pulse = 1'b1;
            retry_d   = retry_inc;
            tmr_d     = POLL_LOAD;
            state_d   = BACKOFF;
          end else begin
            tmr_d   = GAP_LOAD;
            state_d = INIT_GAP;
          end
        end
      end
      INIT_GAP: begin
        if (tmr_q == '0) begin
          if (idx_q == 3'd5) begin
            init_done_d = 1'b1;
            retry_d     = '0;
            state_d     = PTR_ISSUE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = INIT_ISSUE;
          end
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      BACKOFF: begin
        // Fault only once the retry budget has been exceeded, so MAX_RETRY
        // restarts are attempted before giving up.
        if (tmr_q == '0) begin
          init_done_d = 1'b0;
          if (retry_q > RETRY_LIM) begin
            state_d = FAULT;
          end else begin
            idx_d   = '0;
            state_d = INIT_ISSUE;
          end
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      PTR_ISSUE: state_d = PTR_WAIT;
      PTR_WAIT: begin
        if (bus.m_done) begin
          if (bus.m_nack) begin
            err_pulse = 1'b1;
            retry_d   = retry_inc;
            tmr_d     = POLL_LOAD;
            state_d   = BACKOFF;
          end else begin
            tmr_d   = GAP_LOAD;
            state_d = PTR_GAP;
          end
        end
      end
      PTR_GAP: begin
        if (tmr_q == '0) state_d = RD_ISSUE;
        else             tmr_d   = tmr_q - TW'(1);
      end
      RD_ISSUE: begin
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.m_rvalid) begin
          case (cnt_q)
            5'd1:    b1_d = bus.m_rdata;
            5'd2:    b2_d = bus.m_rdata;
            5'd3:    b3_d = bus.m_rdata;
            default: ;
          endcase
          if (cnt_q != 5'd16) cnt_nxt = cnt_q + 5'd1;
        end
        cnt_d = cnt_nxt;
        // A byte arriving with m_done is already counted in cnt_nxt.
        if (bus.m_done) begin
          if (bus.m_nack || (cnt_nxt != 5'd16)) begin
            err_pulse = 1'b1;
            retry_d   = retry_inc;
            tmr_d     = POLL_LOAD;
            state_d   = BACKOFF;
          end else begin
            x_d     = {b3_q[5:4], b1_q};
            y_d     = {b3_q[7:6], b2_q};
            size_d  = b3_q[3:0];
            state_d = PUBLISH;
          end
        end
      end
      PUBLISH: begin
        retry_d = '0;
        tmr_d   = POLL_LOAD;
        state_d = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (tmr_q == '0) state_d = PTR_ISSUE;
        else             tmr_d   = tmr_q - TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.m_start = 1'b0;
    bus.m_rw    = 1'b0;
    bus.m_len   = '0;
    bus.m_wdata = '0;
    case (state_q)
      INIT_ISSUE, INIT_WAIT: begin
        bus.m_start = (state_q == INIT_ISSUE);
        bus.m_len   = 5'd2;
        bus.m_wdata = init_word(idx_q);
      end
      PTR_ISSUE, PTR_WAIT: begin
        bus.m_start = (state_q == PTR_ISSUE);
        bus.m_len   = 5'd1;
        bus.m_wdata = 16'h3600;
      end
      RD_ISSUE, RD_WAIT: begin
        bus.m_start = (state_q == RD_ISSUE);
        bus.m_rw    = 1'b1;
        bus.m_len   = 5'd16;
      end
      default: ;
    endcase
  end

  assign bus.m_addr = DEV_ADDR;
  assign x          = x_q;
  assign y          = y_q;
  assign size       = size_q;
  assign blob_seen  = !((x_q == 10'h3FF) && (y_q == 10'h3FF));
  assign pos_valid  = (state_q == PUBLISH);
  assign init_done  = init_done_q;
  assign busy       = (state_q != IDLE) && (state_q != FAULT);
  assign fault      = (state_q == FAULT);

endmodule

// File: tb/tb_cam_sequencer.sv
// Bench for cam_sequencer: I2C master model with a transaction-sequence scoreboard,
// per-cycle position checks and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_cam_sequencer;
  localparam int unsigned GAP  = 16;
  localparam int unsigned POLL = 64;
  localparam int unsigned MAXR = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] x, y;
  logic [3:0] size;
  logic       blob_seen, pos_valid, init_done, busy, fault, err_pulse;

  cam_sequencer_if bus();

  cam_sequencer #(.DEV_ADDR(7'h58), .GAP_CYCLES(GAP), .POLL_CYCLES(POLL), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .x(x), .y(y), .size(size), .blob_seen(blob_seen), .pos_valid(pos_valid),
    .init_done(init_done), .busy(busy), .fault(fault), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [15:0] init_tab [6] = '{16'h3001, 16'h3008, 16'h0690, 16'h08C0, 16'h1A40, 16'h3333};

  // stimulus-owned configuration
  logic [7:0] rd_bytes [16];
  int rd_len      = 16;
  bit rd_coincide = 1'b0;
  int nack_total  = 0;
  int nack_idx    = 0;
  int stray_tok   = 0;

  // master/model-owned
  int exp_kind = 0;  // 0 init write, 1 pointer write, 2 read
  int exp_idx  = 0;
  int consec   = 0;
  bit exp_fault = 1'b0;
  int exp_err  = 0;
  bit after_pub = 1'b0;
  int nacks_done = 0;
  int pend_x = 1023, pend_y = 1023, pend_size = 0;
  int pend_seq = 0;
  int t_last_done = 0;
  int rd_prog = 0;
  int stray_seen = 0;
  bit fail_seen = 1'b0;
  logic [15:0] restart_wd = '0;

  // compare-owned
  int err_cnt = 0;
  int commit_seq = 0;
  int cx = 1023, cy = 1023, csize = 0;
  int pos_cnt = 0;
  int last_pos_cyc = 0;

  task automatic serve();
    logic        rw;
    logic [4:0]  len;
    logic [15:0] wd;
    logic [7:0]  cp [16];
    int nb, lat;
    bit nk, bad;
    rw = bus.m_rw; len = bus.m_len; wd = bus.m_wdata; cp = rd_bytes;
    chk("no_start_in_fault", exp_fault, 1'b0);
    chk("m_addr", bus.m_addr, 7'h58);
    if (fail_seen) begin restart_wd = wd; fail_seen = 1'b0; end
    case (exp_kind)
      0: begin
        chk("init_rw", rw, 0); chk("init_len", len, 2);
        chk("init_wdata", wd, init_tab[exp_idx]);
        if (exp_idx > 0) chk("init_gap", (cyc - t_last_done) >= GAP, 1);
      end
      1: begin
        chk("ptr_rw", rw, 0); chk("ptr_len", len, 1); chk("ptr_byte", wd[15:8], 8'h36);
        if (after_pub) chk("poll_interval", (cyc - last_pos_cyc) >= POLL && (cyc - last_pos_cyc) <= POLL + 2, 1);
        else           chk("ptr_gap", (cyc - t_last_done) >= GAP, 1);
      end
      default: begin
        chk("rd_rw", rw, 1); chk("rd_len", len, 16);
        chk("rd_gap", (cyc - t_last_done) >= GAP, 1);
      end
    endcase
    nk = (exp_kind == 0) && (exp_idx == nack_idx) && (nacks_done < nack_total);
    if (nk) nacks_done++;
    nb  = rw ? rd_len : 0;
    lat = rw ? ((rd_coincide && nb == 16) ? nb : nb + 2) : 10;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      bus.m_done = 1'b0; bus.m_rvalid = 1'b0; bus.m_nack = 1'b0;
      if (reset) begin rd_prog = 0; return; end
      chk("cmd_stable", (bus.m_rw === rw) && (bus.m_len === len) && (bus.m_wdata === wd), 1);
      rd_prog = rw ? k : 0;
      if (rw && k <= nb) begin bus.m_rvalid = 1'b1; bus.m_rdata = cp[k-1]; end
      if (k == lat) begin bus.m_done = 1'b1; bus.m_nack = nk; end
    end
    @(posedge clk); #1;
    bus.m_done = 1'b0; bus.m_rvalid = 1'b0; bus.m_nack = 1'b0; rd_prog = 0;
    if (reset) return;
    t_last_done = cyc;
    bad = nk || (rw && nb != 16);
    if (bad) begin
      exp_err++; consec++; exp_kind = 0; exp_idx = 0; after_pub = 1'b0; fail_seen = 1'b1;
      if (consec > MAXR) exp_fault = 1'b1;
    end else begin
      case (exp_kind)
        0: if (exp_idx == 5) begin exp_kind = 1; consec = 0; after_pub = 1'b0; end
           else exp_idx++;
        1: exp_kind = 2;
        default: begin
          exp_kind = 1; consec = 0; after_pub = 1'b1;
          pend_x    = ((int'(cp[3]) / 16) % 4) * 256 + int'(cp[1]);
          pend_y    = (int'(cp[3]) / 64) * 256 + int'(cp[2]);
          pend_size = int'(cp[3]) % 16;
          pend_seq++;
        end
      endcase
    end
  endtask

  // I2C master model
  initial begin
    bus.m_done = 1'b0; bus.m_nack = 1'b0; bus.m_rdata = '0; bus.m_rvalid = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        exp_kind = 0; exp_idx = 0; consec = 0; exp_fault = 1'b0; after_pub = 1'b0; rd_prog = 0;
        continue;
      end
      if (stray_seen != stray_tok) begin
        stray_seen = stray_tok;
        bus.m_done = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = 8'h12;
        @(posedge clk); #1;
        bus.m_done = 1'b0; bus.m_rvalid = 1'b0;
      end
      if (start && exp_fault) begin exp_fault = 1'b0; consec = 0; exp_kind = 0; exp_idx = 0; end
      if (bus.m_start) serve();
    end
  end

  // per-cycle position/err tracking
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        cx = 1023; cy = 1023; csize = 0; commit_seq = pend_seq;
        continue;
      end
      if (err_pulse) err_cnt++;
      if (pos_valid) begin
        chk("pos_valid_expected", commit_seq != pend_seq, 1);
        cx = pend_x; cy = pend_y; csize = pend_size; commit_seq = pend_seq;
        pos_cnt++; last_pos_cyc = cyc;
      end
      chk("x", x, cx);
      chk("y", y, cy);
      chk("size", size, csize);
      chk("blob_seen", blob_seen, !(cx == 1023 && cy == 1023));
    end
  end

  task automatic pulse_start();
    @(posedge clk); #2; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2; reset = 1'b1;
    repeat (2) @(posedge clk);
    #2; reset = 1'b0;
  endtask

  task automatic set_bytes(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    for (int i = 0; i < 16; i++) rd_bytes[i] = 8'hFF;
    rd_bytes[1] = b1; rd_bytes[2] = b2; rd_bytes[3] = b3;
  endtask

  task automatic wait_pos(input int target, input int budget);
    for (int i = 0; i < budget && pos_cnt < target; i++) @(posedge clk);
    #2;
    chk("pos_valid_arrived", pos_cnt >= target, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_start"}, bus.m_start, 0);
    chk({tag, "_x"}, x, 10'd1023);
    chk({tag, "_y"}, y, 10'd1023);
    chk({tag, "_size"}, size, 0);
    chk({tag, "_blob_seen"}, blob_seen, 0);
    chk({tag, "_pos_valid"}, pos_valid, 0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_err_pulse"}, err_pulse, 0);
  endtask

  initial begin
    int e0, p0;
    reset = 1'b1; start = 1'b0;
    set_bytes(8'hFF, 8'hFF, 8'hFF);
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (3) @(posedge clk);

    // stray completions in IDLE
    stray_tok++;
    repeat (4) @(posedge clk);
    #2;
    chk("stray_busy", busy, 0);
    chk("stray_err", err_cnt, 0);

    // full init then first read
    set_bytes(8'h20, 8'h30, 8'hA7);
    pulse_start();
    wait_pos(1, 1500);
    chk("pub1_x", x, 10'd544);
    chk("pub1_y", y, 10'd560);
    chk("pub1_size", size, 4'd7);
    chk("pub1_blob", blob_seen, 1);
    chk("pub1_init_done", init_done, 1);
    chk("pub1_busy", busy, 1);

    // start while busy is ignored; all-FF read with byte 16 coincident with done
    pulse_start();
    set_bytes(8'hFF, 8'hFF, 8'hFF);
    rd_coincide = 1'b1;
    wait_pos(2, 500);
    chk("pub2_x", x, 10'd1023);
    chk("pub2_y", y, 10'd1023);
    chk("pub2_size", size, 4'd15);
    chk("pub2_blob", blob_seen, 0);
    rd_coincide = 1'b0;

    // short read of 12 bytes
    e0 = err_cnt; p0 = pos_cnt;
    rd_len = 12;
    set_bytes(8'h55, 8'hAA, 8'h3C);
    for (int i = 0; i < 400 && err_cnt == e0; i++) @(posedge clk);
    rd_len = 16;
    #2;
    chk("short_err", err_cnt, e0 + 1);
    chk("short_no_pub", pos_cnt, p0);
    chk("short_x_kept", x, 10'd1023);
    for (int i = 0; i < 200 && init_done; i++) @(posedge clk);
    #2;
    chk("short_init_restart", init_done, 0);
    wait_pos(p0 + 1, 1500);
    chk("pub3_x", x, 10'd853);
    chk("pub3_y", y, 10'd170);
    chk("pub3_size", size, 4'd12);
    chk("pub3_init_done", init_done, 1);
    chk("short_restart_wd", restart_wd, 16'h3001);

    // NACK on init write 3
    do_reset();
    restart_wd = '0;
    e0 = err_cnt; p0 = pos_cnt;
    nack_idx = 3; nack_total = nacks_done + 1;
    pulse_start();
    wait_pos(p0 + 1, 2000);
    chk("nack3_err", err_cnt, e0 + 1);
    chk("nack3_injected", nacks_done, nack_total);
    chk("nack3_restart_wd", restart_wd, 16'h3001);

    // four consecutive NACKed init attempts -> fault
    do_reset();
    e0 = err_cnt;
    nack_idx = 0; nack_total = nacks_done + 4;
    pulse_start();
    for (int i = 0; i < 2000 && !fault; i++) @(posedge clk);
    #2;
    chk("fault_set", fault, 1);
    chk("fault_busy", busy, 0);
    chk("fault_init_done", init_done, 0);
    chk("fault_errs", err_cnt, e0 + 4);
    repeat (20) @(posedge clk);
    #2;
    chk("fault_sticky", fault, 1);
    p0 = pos_cnt;
    pulse_start();
    chk("fault_cleared", fault, 0);
    chk("fault_restart_busy", busy, 1);
    wait_pos(p0 + 1, 2000);
    chk("fault_recovered_init", init_done, 1);

    // reset in the middle of a read
    for (int i = 0; i < 600 && rd_prog < 5; i++) @(posedge clk);
    #2;
    chk("read_in_progress", rd_prog >= 5, 1);
    #1; reset = 1'b1; #1;
    check_reset_outputs("midrd");
    repeat (2) @(posedge clk);
    #2; reset = 1'b0;
    p0 = pos_cnt;
    pulse_start();
    wait_pos(p0 + 1, 1500);
    chk("rerun_init_done", init_done, 1);

    repeat (3) @(posedge clk);
    #2;
    chk("err_total", err_cnt, exp_err);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
